// File: rtl/ctrl_pkg.sv
// Shared encodings for the micro-sequencer: next-state selects, microaddress map,
// RV32I opcode/funct3 values and the control-word field layout of the 32x28 ROM.
package ctrl_pkg;

  typedef enum logic [1:0] {
    NSSEL_DIRECT    = 2'b00,
    NSSEL_DISPATCH1 = 2'b01,
    NSSEL_DISPATCH2 = 2'b10,
    NSSEL_COND      = 2'b11
  } nssel_e;

  // Microaddress map of the microcode ROM.
  localparam int UA_START0 = 0;
  localparam int UA_ADS1   = 1;
  localparam int UA_LUI1   = 2;
  localparam int UA_STR1   = 3;
  localparam int UA_AUIPC1 = 4;
  localparam int UA_OPRR1  = 5;
  localparam int UA_OPRRI1 = 7;
  localparam int UA_LDI1   = 9;
  localparam int UA_BCH1   = 12;
  localparam int UA_JAS1   = 16;
  localparam int UA_TRAP   = 31;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Control-word layout (28 bits); the sequencer consumes the fields listed here.
  localparam int CW_W           = 28;
  localparam int CW_NSSEL_MSB   = 27;
  localparam int CW_NSSEL_LSB   = 26;
  localparam int CW_DBIN_MSB    = 25;
  localparam int CW_DBIN_LSB    = 21;
  localparam int CW_MEMCNTL_MSB = 20;
  localparam int CW_MEMCNTL_LSB = 18;
  localparam int CW_IRECNTL_BIT = 17;

endpackage

// File: rtl/useq_dispatch.sv
// Combinational opcode-to-microaddress decode: primary dispatch on the incoming
// instruction and secondary dispatch on the latched one.
module useq_dispatch
  import ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [6:0]    opc_pri,
  input  logic [6:0]    opc_sec,
  output logic [AW-1:0] ua_pri,
  output logic          pri_illegal,
  output logic [AW-1:0] ua_sec
);

  always_comb begin
    ua_pri      = AW'(UA_START0);
    pri_illegal = 1'b0;
    case (opc_pri)
      OPC_LUI:    ua_pri = AW'(UA_LUI1);
      OPC_AUIPC:  ua_pri = AW'(UA_AUIPC1);
      OPC_OP:     ua_pri = AW'(UA_OPRR1);
      OPC_OP_IMM: ua_pri = AW'(UA_OPRRI1);
      OPC_LOAD:   ua_pri = AW'(UA_ADS1);
      OPC_STORE:  ua_pri = AW'(UA_ADS1);
      OPC_BRANCH: ua_pri = AW'(UA_BCH1);
      OPC_JAL:    ua_pri = AW'(UA_JAS1);
      OPC_JALR:   ua_pri = AW'(UA_JAS1);
      default:    pri_illegal = 1'b1;
    endcase
  end

  always_comb begin
    ua_sec = AW'(UA_START0);
    case (opc_sec)
      OPC_STORE: ua_sec = AW'(UA_STR1);
      OPC_LOAD:  ua_sec = AW'(UA_LDI1);
      default:   ua_sec = AW'(UA_START0);
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-microaddress generator for the registered microcode ROM.
// Optional USEQ_ILLEGAL_TRAP_EN: illegal opcodes jump to the trap word and raise a sticky flag.
module micro_sequencer
  import ctrl_pkg::*;
#(
  parameter int AW    = 5,
  parameter int IW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       nssel,
  input  logic [AW-1:0]    dbin,
  input  logic [2:0]       memcntl,
  input  logic             irecntl,
  input  logic [IW-1:0]    ir_in,
  input  logic             mem_ready,
  input  logic             flag_z,
  input  logic             flag_lt,
  input  logic             flag_ltu,
  output logic [AW-1:0]    addr,
`ifdef USEQ_ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [IW-1:0]    ir_q,
  output logic             stall,
  output logic [CNT_W-1:0] instret
);

  logic [AW-1:0] cur_addr;
  logic          boot;
  logic [AW-1:0] ua_pri;
  logic [AW-1:0] ua_sec;
  logic          pri_illegal;
  logic          taken;
  logic          dispatch_fire;
  logic          count_en;

  useq_dispatch #(.AW(AW)) u_dispatch (
    .opc_pri     (ir_in[6:0]),
    .opc_sec     (ir_q[6:0]),
    .ua_pri      (ua_pri),
    .pri_illegal (pri_illegal),
    .ua_sec      (ua_sec)
  );

  // Memory handshake: a control word with memcntl!=0 opens an access; the access
  // completes in the cycle mem_ready is high. Until then addr re-issues cur_addr so
  // the ROM keeps presenting the same control word. The boot cycle never stalls.
  assign stall = (memcntl != 3'b000) && !mem_ready && !boot;

  always_comb begin
    taken = 1'b0;
    case (ir_q[14:12])
      F3_BEQ:  taken = flag_z;
      F3_BNE:  taken = !flag_z;
      F3_BLT:  taken = flag_lt;
      F3_BGE:  taken = !flag_lt;
      F3_BLTU: taken = flag_ltu;
      F3_BGEU: taken = !flag_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    addr = AW'(UA_START0);
    if (boot) begin
      addr = AW'(UA_START0);
    end else if (stall) begin
      addr = cur_addr;
    end else begin
      case (nssel_e'(nssel))
        NSSEL_DIRECT:    addr = dbin;
`ifdef USEQ_ILLEGAL_TRAP_EN
        NSSEL_DISPATCH1: addr = pri_illegal ? {AW{1'b1}} : ua_pri;
`else
        NSSEL_DISPATCH1: addr = ua_pri;
`endif
        NSSEL_DISPATCH2: addr = ua_sec;
        NSSEL_COND:      addr = {dbin[AW-1:1], taken};
        default:         addr = AW'(UA_START0);
      endcase
    end
  end

  assign dispatch_fire = !boot && !stall && (nssel_e'(nssel) == NSSEL_DISPATCH1);

`ifdef USEQ_ILLEGAL_TRAP_EN
  assign count_en = dispatch_fire && !pri_illegal;
`else
  assign count_en = dispatch_fire;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot     <= 1'b1;
      cur_addr <= '0;
      ir_q     <= '0;
      instret  <= '0;
    end else begin
      boot     <= 1'b0;
      cur_addr <= addr;
      if (dispatch_fire && irecntl) begin
        ir_q <= ir_in;
      end
      if (count_en) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

`ifdef USEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (dispatch_fire && pri_illegal) begin
      illegal <= 1'b1;
    end
  end
`endif

endmodule
